vjtag_cmd_xfer: RTL and testbench

//  Parametrised vJTAG command front end in the TCK domain. Decodes IR into CH_CNT write

---
 rtl/vjtag_cmd_xfer_pkg.sv | 34 +++
 rtl/vjtag_cmd_xfer_if.sv | 34 +++
 rtl/vjtag_cmd_xfer_bit_sync.sv | 25 ++
 rtl/vjtag_cmd_xfer.sv | 145 ++++++++++++++
 tb/tb_vjtag_cmd_xfer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vjtag_cmd_xfer_pkg.sv
// Package: vjtag_xfer_pkg
// Shared definitions for the vJTAG command front end:
//  - command code helpers (write / readback / status)
//  - status register field positions
//  - command kind and transfer state enums
package vjtag_xfer_pkg;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DROP_LSB = 8;
  localparam int DROP_W        = 8;

  typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_STAT, CMD_BYP} cmd_kind_t;

  // Transfer state is never stored; it is derived from req vs synced ack.
  typedef enum logic {ST_IDLE, ST_PEND} xfer_state_t;

  function automatic int unsigned wr_code(int unsigned i);
    return i;
  endfunction

  function automatic int unsigned rd_code(int unsigned i, int unsigned ch_cnt = 7);
    return ch_cnt + i;
  endfunction

  function automatic int unsigned stat_code(int unsigned ch_cnt = 7);
    return 2 * ch_cnt;
  endfunction

  // Channel index width; never zero so a single channel still has a port.
  function automatic int ch_width(int ch_cnt);
    return (ch_cnt > 1) ? $clog2(ch_cnt) : 1;
  endfunction

endpackage

// File: rtl/vjtag_cmd_xfer_if.sv
// Interface: vjtag_cmd_xfer_if
// Write hand-off bundle between the TCK-domain front end (master) and the
// system-clock receiver (slave).
//  wr_req_tgl_o  toggles once per accepted write
//  wr_ch_o       channel of the pending write
//  wr_data_o     payload of the pending write
//  busy_o        write pending
//  wr_ack_tgl_i  ack toggle returned by the receiver
interface vjtag_cmd_xfer_if
  import vjtag_xfer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CH_CNT = 7
) ();

  localparam int CH_W = ch_width(CH_CNT);

  logic              wr_req_tgl_o;
  logic [CH_W-1:0]   wr_ch_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              busy_o;
  logic              wr_ack_tgl_i;

  modport master (
    output wr_req_tgl_o, wr_ch_o, wr_data_o, busy_o,
    input  wr_ack_tgl_i
  );

  modport slave (
    input  wr_req_tgl_o, wr_ch_o, wr_data_o, busy_o,
    output wr_ack_tgl_i
  );

endinterface

// File: rtl/vjtag_cmd_xfer_bit_sync.sv
// Module: bit_sync
// Asynchronous-reset flop chain bringing a single-bit signal into jclk.
//  jclk   in  destination clock
//  rst_i  in  async active-high reset, clears the chain
//  d_i    in  asynchronous input
//  q_o    out synchronised output, SYNC_D jclk later
module bit_sync #(
  parameter int SYNC_D = 2
) (
  input  logic jclk,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_D-1:0] chain_q;

  always_ff @(posedge jclk or posedge rst_i) begin
    if (rst_i) chain_q <= '0;
    else       chain_q <= {chain_q[SYNC_D-2:0], d_i};
  end

  assign q_o = chain_q[SYNC_D-1];

endmodule

// File: rtl/vjtag_cmd_xfer.sv
// Module: vjtag_cmd_xfer
// vJTAG command front end in the TCK domain. Decodes IR into CH_CNT write
// channels, CH_CNT readback channels and a status register, shifts DR data
// LSB first, and hands each completed write to the system domain with a
// toggle req/ack handshake. Writes arriving while one is pending are
// dropped and counted (saturating).
//  jclk, rst_i          TCK and async active-high reset
//  tdi_i, tdo_o         vJTAG serial data
//  ir_in_i              vJTAG IR
//  cdr_i, sdr_i, udr_i  virtual capture / shift / update DR states
//  rd_data_i            readback words, channel i at [i*DATA_W +: DATA_W]
//  xfer                 write hand-off bundle (master side)
module vjtag_cmd_xfer
  import vjtag_xfer_pkg::*;
#(
  parameter int IR_W   = 4,
  parameter int DATA_W = 32,
  parameter int CH_CNT = 7,
  parameter int SYNC_D = 2
) (
  input  logic                     jclk,
  input  logic                     rst_i,
  input  logic                     tdi_i,
  output logic                     tdo_o,
  input  logic [IR_W-1:0]          ir_in_i,
  input  logic                     cdr_i,
  input  logic                     sdr_i,
  input  logic                     udr_i,
  input  logic [CH_CNT*DATA_W-1:0] rd_data_i,
  vjtag_cmd_xfer_if.master         xfer
);

  localparam int CH_W = ch_width(CH_CNT);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              req_q, req_d;
  logic              udr_q;
  logic              ack_s;
  logic              pend;
  logic              udr_rise;
  xfer_state_t       state;
  cmd_kind_t         cmd_kind;
  logic [CH_W-1:0]   cmd_ch;
  logic [DATA_W-1:0] stat_word;

  bit_sync #(.SYNC_D(SYNC_D)) u_ack_sync (
    .jclk  (jclk),
    .rst_i (rst_i),
    .d_i   (xfer.wr_ack_tgl_i),
    .q_o   (ack_s)
  );

  assign pend     = req_q ^ ack_s;
  assign state    = pend ? ST_PEND : ST_IDLE;
  assign udr_rise = udr_i & ~udr_q;

  always_comb begin
    cmd_kind = CMD_BYP;
    cmd_ch   = '0;
    for (int i = 0; i < CH_CNT; i++) begin
      if (ir_in_i == IR_W'(wr_code(i))) begin
        cmd_kind = CMD_WR;
        cmd_ch   = CH_W'(i);
      end
      if (ir_in_i == IR_W'(rd_code(i, CH_CNT))) begin
        cmd_kind = CMD_RD;
        cmd_ch   = CH_W'(i);
      end
    end
    if (ir_in_i == IR_W'(stat_code(CH_CNT))) cmd_kind = CMD_STAT;
  end

  always_comb begin
    stat_word                              = '0;
    stat_word[STAT_DROP_LSB +: DROP_W]     = drop_q;
    stat_word[STAT_BUSY_BIT]               = pend;
  end

  // Next-state logic: capture/shift of the DR, and on a UDR rising edge
  // either launch a write (idle), count a drop (pending) or clear the
  // drop counter (STAT).
  always_comb begin
    sr_d   = sr_q;
    data_d = data_q;
    ch_d   = ch_q;
    drop_d = drop_q;
    req_d  = req_q;

    if (cdr_i) begin
      case (cmd_kind)
        CMD_RD:   sr_d = rd_data_i[int'(cmd_ch)*DATA_W +: DATA_W];
        CMD_STAT: sr_d = stat_word;
        default:  sr_d = sr_q;
      endcase
    end else if (sdr_i && cmd_kind != CMD_BYP) begin
      sr_d = {tdi_i, sr_q[DATA_W-1:1]};
    end

    if (udr_rise) begin
      case (cmd_kind)
        CMD_WR: begin
          if (state == ST_IDLE) begin
            ch_d   = cmd_ch;
            data_d = sr_q;
            req_d  = ~req_q;
          end else if (drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
          end
        end
        CMD_STAT: drop_d = '0;
        default:  drop_d = drop_q;
      endcase
    end
  end

  always_ff @(posedge jclk or posedge rst_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      data_q <= '0;
      ch_q   <= '0;
      drop_q <= '0;
      req_q  <= 1'b0;
      udr_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      drop_q <= drop_d;
      req_q  <= req_d;
      udr_q  <= udr_i;
    end
  end

  // Reset forces the bypass path so the scan chain stays transparent.
  assign tdo_o = (!rst_i && cmd_kind != CMD_BYP) ? sr_q[0] : tdi_i;

  assign xfer.wr_req_tgl_o = req_q;
  assign xfer.wr_ch_o      = ch_q;
  assign xfer.wr_data_o    = data_q;
  assign xfer.busy_o       = pend;

endmodule

// File: tb/tb_vjtag_cmd_xfer.sv
// Testbench: tb_vjtag_cmd_xfer
// Table of scan vectors, hand-written corner sequences, then random
// operations checked against a transaction-level model of the front end.
module tb_vjtag_cmd_xfer;

  localparam int IR_W   = 4;
  localparam int DATA_W = 32;
  localparam int CH_CNT = 7;
  localparam int SYNC_D = 2;
  localparam int CH_W   = $clog2(CH_CNT);
  localparam logic [IR_W-1:0] IR_BYP  = 4'd15;
  localparam logic [IR_W-1:0] IR_STAT = 4'(2*CH_CNT);

  typedef struct {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] shiftIn;
    bit                ackBefore;
    logic [CH_W-1:0]   expCh;
    logic [DATA_W-1:0] expData;
    bit                expBusy;
    logic [DATA_W-1:0] expTdo;
  } vecT;

  logic                     jclk = 1'b0;
  logic                     rstI;
  logic                     tdi;
  logic                     tdo;
  logic [IR_W-1:0]          irIn;
  logic                     cdr;
  logic                     sdr;
  logic                     udr;
  logic [CH_CNT*DATA_W-1:0] rdData;

  int vectors     = 0;
  int miscompares = 0;

  int                mAccepted;
  int                mAcked;
  int                mDrop;
  logic [CH_W-1:0]   mCh;
  logic [DATA_W-1:0] mData;
  logic [DATA_W-1:0] mDr;

  vjtag_cmd_xfer_if #(.DATA_W(DATA_W), .CH_CNT(CH_CNT)) ifc ();

  vjtag_cmd_xfer #(
    .IR_W   (IR_W),
    .DATA_W (DATA_W),
    .CH_CNT (CH_CNT),
    .SYNC_D (SYNC_D)
  ) dut (
    .jclk      (jclk),
    .rst_i     (rstI),
    .tdi_i     (tdi),
    .tdo_o     (tdo),
    .ir_in_i   (irIn),
    .cdr_i     (cdr),
    .sdr_i     (sdr),
    .udr_i     (udr),
    .rd_data_i (rdData),
    .xfer      (ifc)
  );

  always #5 jclk = ~jclk;

  task automatic tick();
    @(posedge jclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Capture then shift a full DR word; dout collects tdo before each shift.
  task automatic shiftDr(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] din,
                         output logic [DATA_W-1:0] dout);
    irIn = ir;
    cdr  = 1'b1;
    tick();
    cdr = 1'b0;
    sdr = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      tdi = din[i];
      #1;
      dout[i] = tdo;
      tick();
    end
    sdr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic applyStimulus(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] din,
                               output logic [DATA_W-1:0] dout);
    shiftDr(ir, din, dout);
    udr = 1'b1;
    tick();
    udr = 1'b0;
    tick();
  endtask

  task automatic toggleAck();
    ifc.wr_ack_tgl_i = ~ifc.wr_ack_tgl_i;
    repeat (SYNC_D + 1) tick();
  endtask

  task automatic doReset();
    rstI = 1'b1;
    ifc.wr_ack_tgl_i = 1'b0;
    cdr = 1'b0; sdr = 1'b0; udr = 1'b0; tdi = 1'b0;
    irIn = IR_BYP;
    repeat (2) tick();
    rstI = 1'b0;
    tick();
    mAccepted = 0; mAcked = 0; mDrop = 0;
    mCh = '0; mData = '0; mDr = '0;
  endtask

  function automatic logic [DATA_W-1:0] statWord(int drop, bit busy);
    return DATA_W'(drop * 256 + int'(busy));
  endfunction

  task automatic checkModel(input string tag);
    checkOutput({tag, "_ch"},   DATA_W'(ifc.wr_ch_o), DATA_W'(mCh));
    checkOutput({tag, "_data"}, ifc.wr_data_o, mData);
    checkOutput({tag, "_busy"}, DATA_W'(ifc.busy_o), DATA_W'(mAccepted != mAcked));
    checkOutput({tag, "_req"},  DATA_W'(ifc.wr_req_tgl_o), DATA_W'(mAccepted % 2));
  endtask

  initial begin
    vecT               table_v[9];
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] rnd;
    bit                b;

    rstI = 1'b1; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
    tdi = 1'b1; irIn = 4'd2; ifc.wr_ack_tgl_i = 1'b0;
    for (int i = 0; i < CH_CNT; i++)
      rdData[i*DATA_W +: DATA_W] = DATA_W'(32'h1111_1111 * (i + 1));
    #1;
    checkOutput("rst_tdo_bypass", DATA_W'(tdo), 32'd1);
    checkOutput("rst_req", DATA_W'(ifc.wr_req_tgl_o), 32'd0);
    checkOutput("rst_ch", DATA_W'(ifc.wr_ch_o), 32'd0);
    checkOutput("rst_data", ifc.wr_data_o, 32'd0);
    checkOutput("rst_busy", DATA_W'(ifc.busy_o), 32'd0);
    doReset();

    table_v[0] = '{4'd2,  32'h0000_0001, 1'b0, 3'd2, 32'h0000_0001, 1'b1, 32'h0000_0000};
    table_v[1] = '{4'd4,  32'hFFFF_0000, 1'b0, 3'd2, 32'h0000_0001, 1'b1, 32'h0000_0001};
    table_v[2] = '{4'd14, 32'hAAAA_5555, 1'b0, 3'd2, 32'h0000_0001, 1'b1, 32'h0000_0101};
    table_v[3] = '{4'd4,  32'hFFFF_0000, 1'b1, 3'd4, 32'hFFFF_0000, 1'b1, 32'hAAAA_5555};
    table_v[4] = '{4'd9,  32'h5A5A_5A5A, 1'b1, 3'd4, 32'hFFFF_0000, 1'b0, 32'h3333_3333};
    table_v[5] = '{4'd15, 32'h0000_1234, 1'b0, 3'd4, 32'hFFFF_0000, 1'b0, 32'h0000_1234};
    table_v[6] = '{4'd14, 32'hFFFF_FFFF, 1'b0, 3'd4, 32'hFFFF_0000, 1'b0, 32'h0000_0000};
    table_v[7] = '{4'd0,  32'h0BAD_C0DE, 1'b0, 3'd0, 32'h0BAD_C0DE, 1'b1, 32'hFFFF_FFFF};
    table_v[8] = '{4'd13, 32'h0000_0000, 1'b1, 3'd0, 32'h0BAD_C0DE, 1'b0, 32'h7777_7777};

    for (int v = 0; v < 9; v++) begin
      if (table_v[v].ackBefore) toggleAck();
      applyStimulus(table_v[v].ir, table_v[v].shiftIn, dout);
      checkOutput($sformatf("vec%0d_tdo", v), dout, table_v[v].expTdo);
      checkOutput($sformatf("vec%0d_ch", v), DATA_W'(ifc.wr_ch_o), DATA_W'(table_v[v].expCh));
      checkOutput($sformatf("vec%0d_data", v), ifc.wr_data_o, table_v[v].expData);
      checkOutput($sformatf("vec%0d_busy", v), DATA_W'(ifc.busy_o), DATA_W'(table_v[v].expBusy));
    end

    // Write launch latency, and a UDR level held for several cycles.
    doReset();
    shiftDr(4'd3, 32'hDEAD_BEEF, dout);
    udr = 1'b1;
    checkOutput("t1_req_before_edge", DATA_W'(ifc.wr_req_tgl_o), 32'd0);
    tick();
    checkOutput("t1_req_after_edge", DATA_W'(ifc.wr_req_tgl_o), 32'd1);
    checkOutput("t1_ch", DATA_W'(ifc.wr_ch_o), 32'd3);
    checkOutput("t1_data", ifc.wr_data_o, 32'hDEAD_BEEF);
    checkOutput("t1_busy", DATA_W'(ifc.busy_o), 32'd1);
    repeat (2) tick();
    udr = 1'b0;
    tick();
    checkOutput("t1_req_held_udr", DATA_W'(ifc.wr_req_tgl_o), 32'd1);

    // Ack clears busy exactly SYNC_D cycles later.
    ifc.wr_ack_tgl_i = 1'b1;
    for (int k = 1; k <= SYNC_D; k++) begin
      tick();
      checkOutput($sformatf("t2_busy_k%0d", k), DATA_W'(ifc.busy_o), DATA_W'(k < SYNC_D));
    end
    applyStimulus(4'd0, 32'h1234_5678, dout);
    checkOutput("t2_ch", DATA_W'(ifc.wr_ch_o), 32'd0);
    checkOutput("t2_data", ifc.wr_data_o, 32'h1234_5678);
    checkOutput("t2_req", DATA_W'(ifc.wr_req_tgl_o), 32'd0);
    applyStimulus(IR_STAT, 32'd0, dout);
    checkOutput("t2_stat_no_drop", dout, 32'h0000_0001);
    toggleAck();
    checkOutput("t2_busy_done", DATA_W'(ifc.busy_o), 32'd0);

    // Second write while pending is dropped and counted.
    applyStimulus(4'd3, 32'hDEAD_BEEF, dout);
    applyStimulus(4'd1, 32'hCAFE_F00D, dout);
    checkOutput("t3_data_kept", ifc.wr_data_o, 32'hDEAD_BEEF);
    checkOutput("t3_ch_kept", DATA_W'(ifc.wr_ch_o), 32'd3);
    applyStimulus(IR_STAT, 32'd0, dout);
    checkOutput("t3_stat", dout, 32'h0000_0101);
    applyStimulus(IR_STAT, 32'd0, dout);
    checkOutput("t4_stat_cleared", dout, 32'h0000_0001);

    // Drop counter saturation.
    for (int n = 0; n < 300; n++) applyStimulus(4'(n % CH_CNT), $urandom, dout);
    applyStimulus(IR_STAT, 32'd0, dout);
    checkOutput("t4_stat_sat", dout, 32'h0000_FF01);
    applyStimulus(IR_STAT, 32'd0, dout);
    checkOutput("t4_stat_after_clr", dout, 32'h0000_0001);
    checkOutput("t4_data_kept", ifc.wr_data_o, 32'hDEAD_BEEF);

    // Readback and bypass.
    rdData[5*DATA_W +: DATA_W] = 32'hA5A5_0F0F;
    applyStimulus(4'd12, 32'd0, dout);
    checkOutput("t5_rd_ch5", dout, 32'hA5A5_0F0F);
    irIn = IR_BYP;
    sdr  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b   = 1'($urandom);
      tdi = b;
      #1;
      checkOutput($sformatf("t5_bypass%0d", k), DATA_W'(tdo), DATA_W'(b));
      tick();
    end
    sdr = 1'b0;

    // Async reset while a write is pending.
    checkOutput("t6_busy_before", DATA_W'(ifc.busy_o), 32'd1);
    #2;
    rstI = 1'b1;
    ifc.wr_ack_tgl_i = 1'b0;
    #1;
    checkOutput("t6_req", DATA_W'(ifc.wr_req_tgl_o), 32'd0);
    checkOutput("t6_ch", DATA_W'(ifc.wr_ch_o), 32'd0);
    checkOutput("t6_data", ifc.wr_data_o, 32'd0);
    checkOutput("t6_busy", DATA_W'(ifc.busy_o), 32'd0);
    tick();
    rstI = 1'b0;
    tick();
    applyStimulus(4'd6, 32'h600D_600D, dout);
    checkOutput("t6_wr_req", DATA_W'(ifc.wr_req_tgl_o), 32'd1);
    checkOutput("t6_wr_ch", DATA_W'(ifc.wr_ch_o), 32'd6);
    checkOutput("t6_wr_data", ifc.wr_data_o, 32'h600D_600D);

    // Random operations against the transaction model.
    doReset();
    for (int i = 0; i < CH_CNT; i++) rdData[i*DATA_W +: DATA_W] = $urandom;
    for (int n = 0; n < 80; n++) begin
      int op;
      int ch;
      op  = $urandom_range(0, 9);
      ch  = $urandom_range(0, CH_CNT - 1);
      rnd = $urandom;
      if (op >= 8 && mAccepted != mAcked) begin
        toggleAck();
        mAcked++;
      end else if (op <= 3 || op >= 8) begin
        applyStimulus(4'(ch), rnd, dout);
        checkOutput($sformatf("rnd%0d_wr_tdo", n), dout, mDr);
        mDr = rnd;
        if (mAccepted == mAcked) begin
          mAccepted++;
          mCh   = CH_W'(ch);
          mData = rnd;
        end else if (mDrop < 255) begin
          mDrop++;
        end
      end else if (op <= 5) begin
        applyStimulus(4'(CH_CNT + ch), rnd, dout);
        checkOutput($sformatf("rnd%0d_rd_tdo", n), dout, rdData[ch*DATA_W +: DATA_W]);
        mDr = rnd;
      end else if (op == 6) begin
        applyStimulus(IR_STAT, rnd, dout);
        checkOutput($sformatf("rnd%0d_stat_tdo", n), dout, statWord(mDrop, mAccepted != mAcked));
        mDr   = rnd;
        mDrop = 0;
      end else begin
        applyStimulus(IR_BYP, rnd, dout);
        checkOutput($sformatf("rnd%0d_byp_tdo", n), dout, rnd);
      end
      checkModel($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
